// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK receive sequencer: state encoding and the
// default frame sync pattern.
package fsk_pkg;

    // Debug-visible state encoding; values are exported on the state port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DRAIN   = 2'd3
    } fsk_state_e;

    // Default sync word, received MSB first.
    localparam logic [15:0] FSK_SYNC_DEFAULT = 16'hD391;

    // Width of one ADC sample.
    localparam int FSK_SAMPLE_W = 16;

endpackage

// File: rtl/fsk_sample_pacer.sv
// ADC sample pacer: divides sysclk down to the sample rate, latches each
// sample toward the demodulator and marks the last sample of every symbol.
// While i_run is low both counters are held at zero, so the first strobe
// after i_run rises comes exactly SAMPLE_DIV cycles later.
module fsk_sample_pacer
    import fsk_pkg::*;
#(
    parameter int SAMPLE_DIV      = 4,
    parameter int SAMPLES_PER_SYM = 256
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic                    i_run,
    input  logic [FSK_SAMPLE_W-1:0] i_sample,
    output logic                    o_strobe,
    output logic [FSK_SAMPLE_W-1:0] o_sample,
    output logic                    o_sym_done
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SYM_W = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [SYM_W-1:0] SAMP_LAST = SYM_W'(SAMPLES_PER_SYM - 1);

    logic [DIV_W-1:0]        r_div;
    logic [SYM_W-1:0]        r_samp;
    logic                    r_strobe;
    logic                    r_sym_done;
    logic [FSK_SAMPLE_W-1:0] r_sample;

    // Divider and sample-index counters; strobe, symbol mark and latch update together.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_samp     <= '0;
            r_strobe   <= 1'b0;
            r_sym_done <= 1'b0;
            r_sample   <= '0;
        end else begin
            r_strobe   <= 1'b0;
            r_sym_done <= 1'b0;
            if (!i_run) begin
                r_div  <= '0;
                r_samp <= '0;
            end else if (r_div == DIV_LAST) begin
                r_div      <= '0;
                r_strobe   <= 1'b1;
                r_sample   <= i_sample;
                r_sym_done <= (r_samp == SAMP_LAST);
                r_samp     <= (r_samp == SAMP_LAST) ? '0 : r_samp + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_strobe   = r_strobe;
    assign o_sample   = r_sample;
    assign o_sym_done = r_sym_done;

endmodule

// File: rtl/fsk_rx_ctrl.sv
// FSK receive sequencer: paces ADC capture through fsk_sample_pacer, hunts
// for the sync word in the demodulator's bit decisions, assembles the
// payload into bytes and hands them downstream.
//
// Byte handshake: a byte transfers on any rising edge where byte_valid and
// byte_ready are both high. byte_data is held stable while byte_valid is high
// and byte_ready is low; byte_valid drops the cycle after a transfer unless a
// new byte loads on that same edge. A byte completing while the previous one
// is still pending and not being accepted is dropped and flagged on overrun.
module fsk_rx_ctrl
    import fsk_pkg::*;
#(
    parameter int          SAMPLE_DIV      = 4,
    parameter int          SAMPLES_PER_SYM = 256,
    parameter logic [15:0] SYNC_WORD       = FSK_SYNC_DEFAULT,
    parameter int          PAYLOAD_BYTES   = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] sig_from_adc,
    output logic        adc_strobe,
    output logic [15:0] sig_use,
    output logic        sym_done,
    input  logic        dem_valid,
    input  logic        dem_bit,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        frame_done,
    output logic        overrun,
    output logic [1:0]  state
);

    localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

    fsk_state_e  r_state;
    fsk_state_e  w_state_nxt;
    logic [15:0] r_shift;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_bytecnt;
    logic [7:0]  r_asm;
    logic [7:0]  r_byte_data;
    logic        r_byte_valid;
    logic        r_frame_done;
    logic        r_overrun;

    logic        w_run;
    logic        w_xfer;
    logic [15:0] w_shift_in;
    logic [7:0]  w_asm_in;
    logic        w_sync_hit;
    logic        w_byte_done;
    logic        w_drop;
    logic        w_load;

    // Pacing runs in every active state; en low stops it on the same edge.
    assign w_run = en && (r_state != ST_IDLE);

    fsk_sample_pacer #(
        .SAMPLE_DIV      (SAMPLE_DIV),
        .SAMPLES_PER_SYM (SAMPLES_PER_SYM)
    ) u_pacer (
        .sysclk     (sysclk),
        .reset      (reset),
        .i_run      (w_run),
        .i_sample   (sig_from_adc),
        .o_strobe   (adc_strobe),
        .o_sample   (sig_use),
        .o_sym_done (sym_done)
    );

    assign w_xfer      = r_byte_valid && byte_ready;
    assign w_shift_in  = {r_shift[14:0], dem_bit};
    assign w_asm_in    = {r_asm[6:0], dem_bit};
    assign w_sync_hit  = (r_state == ST_HUNT) && dem_valid && (w_shift_in == SYNC_WORD);
    assign w_byte_done = (r_state == ST_PAYLOAD) && dem_valid && (r_bitcnt == 3'd7);
    assign w_drop      = w_byte_done && r_byte_valid && !byte_ready;
    assign w_load      = w_byte_done && !w_drop;

    // State register.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; en low overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_HUNT;
                ST_HUNT:    if (w_sync_hit) w_state_nxt = ST_PAYLOAD;
                ST_PAYLOAD: begin
                    if (w_drop) begin
                        w_state_nxt = ST_HUNT;
                    end else if (w_load && (r_bytecnt == LAST_BYTE)) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN:   if (w_xfer) w_state_nxt = ST_HUNT;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Sync correlator, byte assembler, output byte register and status flags.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_bytecnt    <= '0;
            r_asm        <= '0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (!en) begin
            // Abandon everything, including a pending byte; byte_data keeps its value.
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_bytecnt    <= '0;
            r_asm        <= '0;
            r_byte_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= (r_state == ST_DRAIN) && w_xfer;
            if (w_xfer) begin
                r_byte_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_shift   <= '0;
                    r_bitcnt  <= '0;
                    r_bytecnt <= '0;
                    r_asm     <= '0;
                end
                ST_HUNT: begin
                    if (dem_valid) begin
                        if (w_sync_hit) begin
                            // Start the frame from a clean correlator and assembler.
                            r_shift   <= '0;
                            r_bitcnt  <= '0;
                            r_bytecnt <= '0;
                            r_asm     <= '0;
                        end else begin
                            r_shift <= w_shift_in;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (dem_valid) begin
                        r_asm    <= w_asm_in;
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (w_drop) begin
                            r_overrun <= 1'b1;
                        end
                        if (w_load) begin
                            r_byte_data  <= w_asm_in;
                            r_byte_valid <= 1'b1;
                            r_bytecnt    <= r_bytecnt + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign state      = r_state;

endmodule
